mem_port_sched: RTL and testbench
=================================

Name: mem_port_sched

Overview:
- Shares one single-port synchronous 256x32 RAM between two requesters: the fetch phase (instruction read at pc) and the memory phase (load/store/push/pop at ma or at the stack pointer).
- Arbitrates between them, sequences RAM command/response timing, and owns the stack pointer.
- Sits between the phase-sequenced core and the embedded RAM.

Parameters:
- AW, 8, address width (RAM depth 2^AW)
- DW, 32, data width
- SP_INIT, 8'hFF, stack pointer value after reset
- STARVE_MAX, 3, consecutive lost arbitrations after which fetch is forced to win

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  AW  fetch address (pc), stable while if_req
- if_ack  out  1  one-cycle pulse, if_data valid
- if_data  out  DW  fetched instruction, registered
- dm_req  in  1  data request, held until dm_ack
- dm_op  in  2  00 load, 01 store, 10 push, 11 pop
- dm_addr  in  AW  data address (ma); ignored for push/pop
- dm_wdata  in  DW  store/push data
- dm_ack  out  1  one-cycle pulse, op complete / dm_rdata valid
- dm_rdata  out  DW  load/pop result, registered
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable (valid with ram_en)
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid the cycle after a read command
- sp  out  AW  current stack pointer
- busy  out  1  high when state != IDLE

Behaviour:
- Single clock. rst is synchronous and active-high.
- Reset (any state, including mid-access):
  - state=IDLE; ram_en, ram_we, if_ack, dm_ack = 0.
  - if_data, dm_rdata, ram_addr, ram_wdata = 0; sp=SP_INIT; starve counter=0.
  - The in-flight request is dropped. A requester still holding req is re-arbitrated after reset.
- FSM states: IDLE, CMD, RD, ACK.
- IDLE, in a cycle with any req high:
  - Select a winner.
  - Latch owner, op, effective address and write data.
  - Go to CMD. No RAM activity in IDLE.
- Arbitration:
  - dm_req has priority over if_req.
  - Exception: if starve counter == STARVE_MAX and if_req=1, fetch wins and the counter clears.
  - Counter increments when data wins while if_req=1.
  - Counter clears when fetch wins or if_req=0 in IDLE.
  - Counter saturates; it never wraps.
- Effective address:
  - load/store: dm_addr
  - fetch: if_addr
  - push: sp
  - pop: sp+1 (mod 2^AW)
- CMD:
  - ram_en=1; ram_addr=latched address.
  - ram_we=1 for store/push, with ram_wdata=latched data.
  - Writes go to ACK; reads (fetch/load/pop) go to RD.
- RD: capture ram_rdata into if_data (fetch) or dm_rdata (load/pop), then go to ACK. ram_en=0.
- ACK:
  - Pulse the owner's ack for exactly one cycle.
  - sp updates here: push sp<=sp-1, pop sp<=sp+1, both mod 2^AW.
  - Return to IDLE.
- Latency from the IDLE grant cycle N:
  - write ack at N+2
  - read ack at N+3
  - Next grant no earlier than N+3 (write) or N+4 (read).
- Requesters drop req on the edge after ack; a req seen high in IDLE is always a new request.
- Read-result hold: if_data and dm_rdata hold their value until the next read of the same type. Stores and pushes do not disturb dm_rdata.
- Stack wrap: push at sp=00 writes mem[00], then sp=FF. Pop at sp=FF reads mem[00], then sp=00. No error flag.
- Simultaneous if_req and dm_req: exactly one ack per service. The loser stays pending and is never dropped.
- Outputs are never X after reset. ram_we=0 whenever ram_en=0.

Test Plan:
- Reset, then fetch if_addr=8'h10 with RAM[10]=32'hDEADBEEF → ram_en/ram_addr=10 at N+1; if_ack and if_data=DEADBEEF at N+3; busy=1 for N+1..N+3.
- Store dm_addr=8'h20, data 32'h12345678, then load 8'h20 → store dm_ack at N+2 with ram_we=1 at N+1; load returns 12345678; dm_rdata unchanged by the store.
- After reset, push A, push B, pop, pop → writes at FF then FE; sp=FD; pops read FE then FF giving B then A; sp=FF.
- if_req held high and dm_req back-to-back continuously, STARVE_MAX=3 → grant order D,D,D,F,D,D,D,F; counter clears after each fetch.
- Wrap: sp forced to 00 by 255 pushes after reset → the next push writes mem[00] and sp=FF; a pop reads mem[00] and sp=00.
- Assert rst during RD of a load → next cycle IDLE, no dm_ack, sp=FF, ram_en=0; held dm_req is then re-served normally.

Source files
------------

// File: rtl/mem_port_sched_if.sv
// Bus bundle between the core phases, the port scheduler and the embedded single-port RAM.
interface mem_port_sched_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_data;

    logic          dm_req;
    logic [1:0]    dm_op;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_op, dm_addr, dm_wdata, ram_rdata,
        output if_ack, if_data, dm_ack, dm_rdata, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_op, dm_addr, dm_wdata, ram_rdata,
        input  if_ack, if_data, dm_ack, dm_rdata, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_sched.sv
// Arbitrates fetch and data-phase requests onto one single-port synchronous RAM
// and owns the stack pointer used by push/pop.
module mem_port_sched #(
    parameter int unsigned   AW         = 8,
    parameter int unsigned   DW         = 32,
    parameter logic [AW-1:0] SP_INIT    = AW'(8'hFF),
    parameter int unsigned   STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,
    mem_port_sched_if.slave bus,
    output logic [AW-1:0]   sp,
    output logic            busy
);
    localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, CMD, RD, ACK} state_t;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_STORE = 2'b01, OP_PUSH = 2'b10, OP_POP = 2'b11} op_t;

    state_t        state, state_nxt;
    logic          fetch_q, fetch_nxt;
    op_t           op_q, op_nxt;
    logic [CW-1:0] starve_q, starve_nxt;
    logic [AW-1:0] sp_q, sp_nxt;
    logic          busy_q, busy_nxt;
    logic          ram_en_q, ram_en_nxt;
    logic          ram_we_q, ram_we_nxt;
    logic [AW-1:0] ram_addr_q, ram_addr_nxt;
    logic [DW-1:0] ram_wdata_q, ram_wdata_nxt;
    logic          if_ack_q, if_ack_nxt;
    logic          dm_ack_q, dm_ack_nxt;
    logic [DW-1:0] if_data_q, if_data_nxt;
    logic [DW-1:0] dm_rdata_q, dm_rdata_nxt;
    logic          grant_fetch;
    logic          is_write;

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_nxt     = state;
        fetch_nxt     = fetch_q;
        op_nxt        = op_q;
        starve_nxt    = starve_q;
        sp_nxt        = sp_q;
        ram_en_nxt    = 1'b0;
        ram_we_nxt    = 1'b0;
        ram_addr_nxt  = ram_addr_q;
        ram_wdata_nxt = ram_wdata_q;
        if_ack_nxt    = 1'b0;
        dm_ack_nxt    = 1'b0;
        if_data_nxt   = if_data_q;
        dm_rdata_nxt  = dm_rdata_q;
        grant_fetch   = 1'b0;
        is_write      = !fetch_q && (op_q == OP_STORE || op_q == OP_PUSH);

        unique case (state)
            IDLE: begin
                // Data has priority unless fetch has lost STARVE_MAX times in a row.
                grant_fetch = bus.if_req && (!bus.dm_req || starve_q == CW'(STARVE_MAX));
                if (!bus.if_req || grant_fetch) begin
                    starve_nxt = '0;
                end else if (starve_q != CW'(STARVE_MAX)) begin
                    starve_nxt = starve_q + CW'(1);
                end
                if (bus.if_req || bus.dm_req) begin
                    state_nxt     = CMD;
                    fetch_nxt     = grant_fetch;
                    op_nxt        = op_t'(bus.dm_op);
                    ram_en_nxt    = 1'b1;
                    ram_wdata_nxt = bus.dm_wdata;
                    if (grant_fetch) begin
                        ram_addr_nxt = bus.if_addr;
                    end else begin
                        unique case (op_t'(bus.dm_op))
                            OP_PUSH: ram_addr_nxt = sp_q;
                            OP_POP:  ram_addr_nxt = sp_q + AW'(1);
                            default: ram_addr_nxt = bus.dm_addr;
                        endcase
                        ram_we_nxt = (op_t'(bus.dm_op) == OP_STORE) || (op_t'(bus.dm_op) == OP_PUSH);
                    end
                end
            end
            CMD: begin
                if (is_write) begin
                    state_nxt  = ACK;
                    dm_ack_nxt = 1'b1;
                end else begin
                    state_nxt = RD;
                end
            end
            RD: begin
                state_nxt = ACK;
                if (fetch_q) begin
                    if_data_nxt = bus.ram_rdata;
                    if_ack_nxt  = 1'b1;
                end else begin
                    dm_rdata_nxt = bus.ram_rdata;
                    dm_ack_nxt   = 1'b1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
                if (!fetch_q && op_q == OP_PUSH) sp_nxt = sp_q - AW'(1);
                if (!fetch_q && op_q == OP_POP)  sp_nxt = sp_q + AW'(1);
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_q     <= 1'b0;
            op_q        <= OP_LOAD;
            starve_q    <= '0;
            sp_q        <= SP_INIT;
            busy_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state       <= state_nxt;
            fetch_q     <= fetch_nxt;
            op_q        <= op_nxt;
            starve_q    <= starve_nxt;
            sp_q        <= sp_nxt;
            busy_q      <= busy_nxt;
            ram_en_q    <= ram_en_nxt;
            ram_we_q    <= ram_we_nxt;
            ram_addr_q  <= ram_addr_nxt;
            ram_wdata_q <= ram_wdata_nxt;
            if_ack_q    <= if_ack_nxt;
            dm_ack_q    <= dm_ack_nxt;
            if_data_q   <= if_data_nxt;
            dm_rdata_q  <= dm_rdata_nxt;
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_data   = if_data_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign sp            = sp_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_mem_port_sched.sv
// Scoreboard bench for mem_port_sched: random fetch/data traffic against a
// memory+stack reference model, plus directed latency, stack, starvation and reset cases.
module tb_mem_port_sched;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    logic [AW-1:0] sp;
    logic busy;

    always #5 clk = ~clk;

    mem_port_sched_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_sched #(.AW(AW), .DW(DW), .SP_INIT(8'hFF), .STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .sp  (sp),
        .busy(busy)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 'h10) return 32'hDEADBEEF;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Behavioural single-port RAM with one-cycle read latency.
    logic [DW-1:0] ram_mem [256];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
            bus.ram_rdata <= '0;
        end else if (bus.ram_en) begin
            if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= ram_mem[bus.ram_addr];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [256];
    logic [AW-1:0] ref_sp;
    logic [DW-1:0] ref_last;

    typedef struct {
        logic [DW-1:0] rdata;
        logic [AW-1:0] sp;
    } dm_exp_t;

    logic [DW-1:0] if_q[$];
    dm_exp_t       dm_q[$];
    byte           order_q[$];

    int checks = 0;
    int errors = 0;
    bit sp_chk_pend = 0;
    logic [AW-1:0] sp_chk_val;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops expected responses whenever the DUT acks.
    always @(negedge clk) begin
        if (sp_chk_pend) begin
            check("sp_after_ack", sp, sp_chk_val);
            sp_chk_pend = 0;
        end
        if (!rst && !mem_init) begin
            check("we_without_en", bus.ram_we & ~bus.ram_en, 0);
            check("ack_exclusive", bus.if_ack & bus.dm_ack, 0);
            if (bus.if_ack) begin
                order_q.push_back("F");
                check("if_ack_expected", if_q.size() != 0, 1);
                if (if_q.size() != 0) check("if_data", bus.if_data, if_q.pop_front());
            end
            if (bus.dm_ack) begin
                order_q.push_back("D");
                check("dm_ack_expected", dm_q.size() != 0, 1);
                if (dm_q.size() != 0) begin
                    dm_exp_t e;
                    e = dm_q.pop_front();
                    check("dm_rdata", bus.dm_rdata, e.rdata);
                    sp_chk_val  = e.sp;
                    sp_chk_pend = 1;
                end
            end
        end
    end

    // Applies a data op to the reference model and queues its expected response.
    task automatic model_dm(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] w,
                            output logic [AW-1:0] eff);
        case (op)
            2'b00: begin eff = a; ref_last = ref_mem[a]; end
            2'b01: begin eff = a; ref_mem[a] = w; end
            2'b10: begin eff = ref_sp; ref_mem[ref_sp] = w; ref_sp = ref_sp - 8'd1; end
            default: begin ref_sp = ref_sp + 8'd1; eff = ref_sp; ref_last = ref_mem[eff]; end
        endcase
        dm_q.push_back('{rdata: ref_last, sp: ref_sp});
    endtask

    task automatic do_fetch(input logic [AW-1:0] a, input bit chk);
        int n;
        bit got;
        if_q.push_back(ref_mem[a]);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        n = 0;
        got = 0;
        while (!got && n < 80) begin
            @(negedge clk);
            n++;
            if (chk && n == 2) begin
                check("if_cmd_ram_en", bus.ram_en, 1);
                check("if_cmd_ram_we", bus.ram_we, 0);
                check("if_cmd_ram_addr", bus.ram_addr, a);
            end
            if (chk && n >= 2) check("if_busy", busy, 1);
            got = bus.if_ack;
        end
        check("if_ack_seen", got, 1);
        if (chk) check("if_latency", n, 4);
        @(posedge clk);
        #1 bus.if_req = 1'b0;
    endtask

    task automatic do_dm(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] w, input bit chk);
        int n;
        bit got;
        bit wr;
        logic [AW-1:0] eff;
        wr = (op == 2'b01) || (op == 2'b10);
        model_dm(op, a, w, eff);
        bus.dm_req   = 1'b1;
        bus.dm_op    = op;
        bus.dm_addr  = a;
        bus.dm_wdata = w;
        n = 0;
        got = 0;
        while (!got && n < 80) begin
            @(negedge clk);
            n++;
            if (chk && n == 2) begin
                check("dm_cmd_ram_en", bus.ram_en, 1);
                check("dm_cmd_ram_we", bus.ram_we, wr);
                check("dm_cmd_ram_addr", bus.ram_addr, eff);
                if (wr) check("dm_cmd_ram_wdata", bus.ram_wdata, w);
            end
            if (chk && n >= 2) check("dm_busy", busy, 1);
            got = bus.dm_ack;
        end
        check("dm_ack_seen", got, 1);
        if (chk) check("dm_latency", n, wr ? 3 : 4);
        @(posedge clk);
        #1 bus.dm_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_if_ack", bus.if_ack, 0);
        check("rst_dm_ack", bus.dm_ack, 0);
        check("rst_if_data", bus.if_data, 0);
        check("rst_dm_rdata", bus.dm_rdata, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_wdata", bus.ram_wdata, 0);
        check("rst_sp", sp, 8'hFF);
        check("rst_busy", busy, 0);
        ref_sp   = 8'hFF;
        ref_last = '0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int depth;
        bit got;
        logic [AW-1:0] eff;
        rst = 1'b1;
        mem_init = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_op = 2'b00; bus.dm_addr = '0; bus.dm_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        @(posedge clk);
        #1 mem_init = 1'b0;
        do_reset();

        // Directed fetch, store and load timing
        do_fetch(8'h10, 1);
        do_dm(2'b01, 8'h20, 32'h12345678, 1);
        do_dm(2'b00, 8'h20, '0, 1);

        // Stack push/pop order after reset
        do_reset();
        do_dm(2'b10, '0, 32'hAAAA0001, 1);
        do_dm(2'b10, '0, 32'hBBBB0002, 1);
        check("sp_after_pushes", sp, 8'hFD);
        do_dm(2'b11, '0, '0, 1);
        do_dm(2'b11, '0, '0, 1);
        check("sp_after_pops", sp, 8'hFF);

        // Starvation: fetch held, data back-to-back
        do_reset();
        order_q.delete();
        fork
            begin repeat (2) do_fetch(8'($urandom_range(0, 63)), 0); end
            begin repeat (6) do_dm(2'b00, 8'($urandom_range(64, 127)), '0, 0); end
        join
        check("starve_order_len", order_q.size(), 8);
        for (int i = 0; i < 8 && i < order_q.size(); i++)
            check($sformatf("starve_order_%0d", i), order_q[i], (i % 4 == 3) ? "F" : "D");

        // Random concurrent traffic
        depth = 0;
        fork
            begin
                repeat (30) begin
                    do_fetch(8'($urandom_range(0, 63)), 0);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
            end
            begin
                repeat (60) begin
                    logic [1:0] op;
                    op = 2'($urandom_range(0, 3));
                    if (op == 2'b11 && depth == 0) op = 2'b10;
                    if (op == 2'b10 && depth >= 16) op = 2'b11;
                    if (op == 2'b10) depth++;
                    if (op == 2'b11) depth--;
                    do_dm(op, 8'($urandom_range(64, 127)), $urandom, 0);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
            end
        join

        // Stack wrap
        do_reset();
        repeat (255) do_dm(2'b10, '0, $urandom, 0);
        check("sp_before_wrap", sp, 8'h00);
        do_dm(2'b10, '0, 32'hC0FFEE00, 1);
        check("sp_after_wrap_push", sp, 8'hFF);
        do_dm(2'b11, '0, '0, 1);
        check("sp_after_wrap_pop", sp, 8'h00);

        // Reset during RD of a load, request held across reset
        do_reset();
        do_dm(2'b10, '0, 32'h0BADF00D, 0);
        bus.dm_req = 1'b1; bus.dm_op = 2'b00; bus.dm_addr = 8'h44; bus.dm_wdata = '0;
        repeat (2) @(negedge clk);
        check("rd_rst_cmd_en", bus.ram_en, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rd_rst_busy", busy, 0);
        check("rd_rst_dm_ack", bus.dm_ack, 0);
        check("rd_rst_ram_en", bus.ram_en, 0);
        check("rd_rst_sp", sp, 8'hFF);
        check("rd_rst_dm_rdata", bus.dm_rdata, 0);
        ref_sp = 8'hFF;
        ref_last = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_dm(2'b00, 8'h44, '0, eff);
        got = 0;
        for (int n = 0; n < 80 && !got; n++) begin
            @(negedge clk);
            got = bus.dm_ack;
        end
        check("rd_rst_reserved", got, 1);
        @(posedge clk);
        #1 bus.dm_req = 1'b0;

        repeat (4) @(posedge clk);
        check("if_q_drained", if_q.size(), 0);
        check("dm_q_drained", dm_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
